// File: rtl/multdiv_checker.sv
// Online checker for a signed multiply/divide unit: captures the issued operands,
// waits for the unit's result, recomputes it with a shift-add multiplier and reports a verdict.
module multdiv_checker #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] data_operandA,
   input  logic [15:0] data_operandB,
   input  logic [31:0] md_result,
   input  logic [31:0] md_remainder,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        check_busy,
   output logic        check_done,
   output logic        fault_detected,
   output logic        timeout,
   output logic        fault_sticky,
   output logic [7:0]  fault_count,
   output logic [15:0] op_count
);
   localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned ITER_W = 5;
   localparam int unsigned PROD_W = 48;

   typedef enum logic [1:0] {IDLE, WAIT_RDY, COMPUTE, COMPARE} state_t;

   state_t state, next_state;

   logic [31:0]       a_reg, res_reg, rem_reg;
   logic [15:0]       b_reg;
   logic              is_div, exc_reg, timed_out;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ITER_W-1:0] iter;
   logic [PROD_W-1:0] mcand, acc;
   logic [15:0]       mplier;
   logic              neg;

   logic              start_ok, wait_last, last_iter;
   logic [31:0]       mcand_src, mcand_mag, rem_mag;
   logic [15:0]       b_mag;
   logic [PROD_W-1:0] prod;
   logic              mult_exc_c, fault_c;

   assign start_ok  = start_mult ^ start_div;
   assign wait_last = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign last_iter = (iter == ITER_W'(16));
   assign mcand_src = is_div ? res_reg : a_reg;
   assign mcand_mag = mcand_src[31] ? 32'(-mcand_src) : mcand_src;
   assign b_mag     = b_reg[15] ? 16'(-b_reg) : b_reg;
   assign rem_mag   = rem_reg[31] ? 32'(-rem_reg) : rem_reg;
   assign prod      = neg ? PROD_W'(-acc) : acc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start_ok) next_state = WAIT_RDY;
         WAIT_RDY: if (md_resultRDY) next_state = COMPUTE;
                   else if (wait_last) next_state = COMPARE;
         COMPUTE:  if (last_iter) next_state = COMPARE;
         COMPARE:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Verdict for the check sitting in COMPARE; a timeout overrides everything.
   always_comb begin
      mult_exc_c = ~((&prod[47:31]) | ~(|prod[47:31]));
      fault_c    = 1'b0;
      if (timed_out) begin
         fault_c = 1'b1;
      end else if (!is_div) begin
         fault_c = (exc_reg != mult_exc_c) || (!exc_reg && (res_reg != prod[31:0]));
      end else if (b_reg == 16'd0) begin
         fault_c = !exc_reg;
      end else begin
         fault_c = exc_reg
                || ((prod[31:0] + rem_reg) != a_reg)
                || (rem_mag >= {16'd0, b_mag})
                || ((rem_reg != 32'd0) && (rem_reg[31] != a_reg[31]));
      end
   end

   // Operand capture, result capture and the shift-add datapath.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         is_div    <= 1'b0;
         res_reg   <= '0;
         rem_reg   <= '0;
         exc_reg   <= 1'b0;
         timed_out <= 1'b0;
         wait_cnt  <= '0;
         iter      <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         neg       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               a_reg     <= data_operandA;
               b_reg     <= data_operandB;
               is_div    <= start_div;
               timed_out <= 1'b0;
               wait_cnt  <= '0;
            end
            WAIT_RDY: begin
               if (md_resultRDY) begin
                  res_reg <= md_result;
                  rem_reg <= md_remainder;
                  exc_reg <= md_exception;
                  iter    <= '0;
               end else if (wait_last) begin
                  timed_out <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            COMPUTE: begin
               // First COMPUTE cycle loads magnitudes; the next 16 each retire one multiplier bit.
               if (iter == '0) begin
                  mcand  <= {16'd0, mcand_mag};
                  mplier <= b_mag;
                  acc    <= '0;
                  neg    <= mcand_src[31] ^ b_reg[15];
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= {mcand[PROD_W-2:0], 1'b0};
                  mplier <= {1'b0, mplier[15:1]};
               end
               iter <= iter + ITER_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         check_busy     <= 1'b0;
         check_done     <= 1'b0;
         fault_detected <= 1'b0;
         timeout        <= 1'b0;
         fault_sticky   <= 1'b0;
         fault_count    <= '0;
         op_count       <= '0;
      end else begin
         check_busy     <= (next_state != IDLE);
         check_done     <= (state == COMPARE);
         fault_detected <= (state == COMPARE) && fault_c;
         timeout        <= (state == COMPARE) && timed_out;
         if (state == COMPARE) begin
            op_count <= op_count + 16'd1;
            if (fault_c) begin
               fault_sticky <= 1'b1;
               if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_multdiv_checker.sv
// Scoreboard bench for multdiv_checker: verdicts pushed at issue, popped on check_done.
module tb_multdiv_checker;
   localparam int unsigned TMO = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] data_operandA;
   logic [15:0] data_operandB;
   logic [31:0] md_result, md_remainder;
   logic        md_exception, md_resultRDY;
   logic        check_busy, check_done, fault_detected, timeout, fault_sticky;
   logic [7:0]  fault_count;
   logic [15:0] op_count;

   multdiv_checker #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .md_result(md_result), .md_remainder(md_remainder), .md_exception(md_exception),
      .md_resultRDY(md_resultRDY), .check_busy(check_busy), .check_done(check_done),
      .fault_detected(fault_detected), .timeout(timeout), .fault_sticky(fault_sticky),
      .fault_count(fault_count), .op_count(op_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        fault;
      logic        tmo;
      logic [15:0] ops;
      logic [7:0]  fcnt;
      logic        sticky;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_ops = '0;
   logic [7:0]  exp_fcnt = '0;
   logic        exp_sticky = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Independent reference built on 64-bit signed arithmetic.
   function automatic bit model_fault(input bit is_div, input logic [31:0] a, input logic [15:0] b,
                                      input logic [31:0] res, input logic [31:0] rem, input logic exc);
      longint la = longint'($signed(a));
      longint lb = longint'($signed(b));
      longint lr = longint'($signed(res));
      longint lm = longint'($signed(rem));
      longint p, s, arem, ab;
      bit ee;
      if (!is_div) begin
         p  = la * lb;
         ee = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         return (exc != ee) || (!exc && (res != p[31:0]));
      end
      if (b == 16'd0) return !exc;
      s    = lr * lb + lm;
      arem = (lm < 0) ? -lm : lm;
      ab   = (lb < 0) ? -lb : lb;
      return exc || (s[31:0] != a) || (arem >= ab) || ((lm != 0) && ((lm < 0) != (la < 0)));
   endfunction

   task automatic push(input bit f, input bit t);
      exp_t e;
      exp_ops = exp_ops + 16'd1;
      if (f) begin
         exp_sticky = 1'b1;
         if (exp_fcnt != 8'hFF) exp_fcnt = exp_fcnt + 8'd1;
      end
      e.fault = f; e.tmo = t; e.ops = exp_ops; e.fcnt = exp_fcnt; e.sticky = exp_sticky;
      sb.push_back(e);
   endtask

   // Called at a negedge; issues immediately so back-to-back calls start in the done cycle.
   task automatic run_op(input string tag, input bit is_div, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] res, input logic [31:0] rem, input logic exc,
                         input bit exp_fault, input int dly, input bit poke);
      int k;
      push(exp_fault, 1'b0);
      data_operandA = a; data_operandB = b;
      start_mult = !is_div; start_div = is_div;
      @(negedge clock);
      start_mult = 1'b0; start_div = 1'b0;
      data_operandA = $urandom; data_operandB = 16'($urandom);
      check_eq({tag, "_busy"}, 32'(check_busy), 32'd1);
      for (int i = 0; i < dly; i++) begin
         if (poke && i == 0) start_mult = 1'b1;
         @(negedge clock);
         start_mult = 1'b0;
      end
      md_result = res; md_remainder = rem; md_exception = exc; md_resultRDY = 1'b1;
      @(negedge clock);
      md_resultRDY = 1'b0; md_result = $urandom; md_remainder = $urandom; md_exception = 1'b0;
      k = 0;
      while (!check_done && k < 40) begin
         @(negedge clock);
         k++;
      end
      check_eq({tag, "_lat"}, 32'(k), 32'd18);
   endtask

   task automatic run_timeout();
      int k;
      push(1'b1, 1'b1);
      data_operandA = 32'd5; data_operandB = 16'd3; start_mult = 1'b1;
      @(negedge clock);
      start_mult = 1'b0;
      k = 0;
      while (!check_done && k < 200) begin
         @(negedge clock);
         k++;
      end
      check_eq("tmo_lat", 32'(k), 32'(TMO + 1));
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (check_done) begin
            if (sb.size() == 0) begin
               check_eq("sb_size", 32'(sb.size()), 32'd1);
            end else begin
               mon_e = sb.pop_front();
               check_eq("fault", 32'(fault_detected), 32'(mon_e.fault));
               check_eq("timeout", 32'(timeout), 32'(mon_e.tmo));
               check_eq("op_count", 32'(op_count), 32'(mon_e.ops));
               check_eq("fault_count", 32'(fault_count), 32'(mon_e.fcnt));
               check_eq("sticky", 32'(fault_sticky), 32'(mon_e.sticky));
            end
         end else begin
            check_eq("quiet", 32'({fault_detected, timeout}), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      longint la, lb, p, q, r;
      logic [31:0] a, res, rem;
      logic [15:0] b;
      logic        exc;
      int          mode;

      reset = 1'b1; start_mult = 1'b0; start_div = 1'b0;
      data_operandA = '0; data_operandB = '0;
      md_result = '0; md_remainder = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_outs", 32'({check_busy, check_done, fault_detected, timeout, fault_sticky}), 32'd0);
      check_eq("rst_cnts", {fault_count, 8'd0, op_count}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Reset during COMPUTE iteration 8 discards the check.
      data_operandA = 32'd7; data_operandB = 16'hFFFD; start_mult = 1'b1;
      @(negedge clock);
      start_mult = 1'b0;
      md_result = 32'hFFFF_FFEB; md_resultRDY = 1'b1;
      @(negedge clock);
      md_resultRDY = 1'b0;
      repeat (8) @(negedge clock);
      check_eq("mid_busy", 32'(check_busy), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("async_busy", 32'(check_busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      check_eq("mid_outs", 32'({check_busy, check_done, fault_detected, timeout, fault_sticky}), 32'd0);
      check_eq("mid_cnts", {fault_count, 8'd0, op_count}, 32'd0);
      repeat (25) @(negedge clock);
      check_eq("mid_after", {fault_count, 7'd0, check_done, op_count}, 32'd0);

      run_op("m_ok",    1'b0, 32'd7, 16'hFFFD, 32'hFFFF_FFEB, 32'd0, 1'b0, 1'b0, 0, 1'b0);
      run_op("m_bad",   1'b0, 32'd7, 16'hFFFD, 32'hFFFF_FFEC, 32'd0, 1'b0, 1'b1, 2, 1'b0);
      run_op("d_ok",    1'b1, 32'd100, 16'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1, 1'b0);
      run_op("d_q",     1'b1, 32'd100, 16'd7, 32'd15, 32'd2, 1'b0, 1'b1, 3, 1'b1);
      run_op("d_r",     1'b1, 32'd100, 16'd7, 32'd13, 32'd9, 1'b0, 1'b1, 0, 1'b0);
      run_op("d0_exc",  1'b1, 32'd55, 16'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
      run_op("d0_noex", 1'b1, 32'd55, 16'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0, 1'b0);
      run_op("m_edge",  1'b0, 32'h0001_0000, 16'h4000, 32'h4000_0000, 32'd0, 1'b0, 1'b0, 4, 1'b1);
      run_op("m_ovf",   1'b0, 32'h0002_0000, 16'h4000, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 0, 1'b0);
      run_op("m_ovfex", 1'b0, 32'h0002_0000, 16'h4000, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 0, 1'b0);
      run_op("d_neg",   1'b1, 32'hFFFF_FF9C, 16'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 2, 1'b0);
      run_op("d_rsign", 1'b1, 32'hFFFF_FF9C, 16'd7, 32'hFFFF_FFF1, 32'd5, 1'b0, 1'b1, 0, 1'b0);
      run_op("d_exc",   1'b1, 32'd100, 16'd7, 32'd14, 32'd2, 1'b1, 1'b1, 0, 1'b0);

      // Simultaneous starts are ignored.
      data_operandA = 32'd9; data_operandB = 16'd2; start_mult = 1'b1; start_div = 1'b1;
      @(negedge clock);
      start_mult = 1'b0; start_div = 1'b0;
      check_eq("both_busy", 32'(check_busy), 32'd0);
      repeat (3) @(negedge clock);
      check_eq("both_ops", 32'(op_count), 32'(exp_ops));

      run_timeout();
      run_op("post_tmo", 1'b0, 32'd3, 16'd3, 32'd9, 32'd0, 1'b0, 1'b0, 0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         a = $urandom; b = 16'($urandom);
         la = longint'($signed(a)); lb = longint'($signed(b));
         p = la * lb;
         res = p[31:0];
         exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         mode = $urandom_range(0, 3);
         if (mode == 0) res = res ^ 32'd1;
         if (mode == 1) exc = !exc;
         run_op("m_rnd", 1'b0, a, b, res, 32'd0, exc,
                model_fault(1'b0, a, b, res, 32'd0, exc), $urandom_range(0, 3), 1'b0);
      end

      for (int n = 0; n < 8; n++) begin
         a = (n < 4) ? 32'($signed(16'($urandom))) : $urandom;
         b = 16'($urandom_range(1, 16'hFFFF));
         la = longint'($signed(a)); lb = longint'($signed(b));
         q = la / lb; r = la % lb;
         mode = $urandom_range(0, 3);
         if (mode == 0) q = q + 1;
         if (mode == 1) begin q = q - 1; r = r + lb; end
         res = q[31:0]; rem = r[31:0];
         run_op("d_rnd", 1'b1, a, b, res, rem, 1'b0,
                model_fault(1'b1, a, b, res, rem, 1'b0), $urandom_range(0, 3), 1'b0);
      end

      repeat (4) @(negedge clock);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      check_eq("end_busy", 32'(check_busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multdiv_checker.md
MULTDIV_CHECKER -- requirements
Module: multdiv_checker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles in WAIT_RDY before the checker declares a timeout fault.
REQ-002 SHALL have ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- start_mult  in  1  one-cycle multiply issue, same pulse driven to the multdiv unit's ctrl_MULT.
- start_div  in  1  one-cycle divide issue, same pulse driven to the multdiv unit's ctrl_DIV.
- data_operandA  in  32  signed operand A.
- data_operandB  in  16  signed operand B.
- md_result  in  32  unit product/quotient.
- md_remainder  in  32  unit remainder.
- md_exception  in  1  unit exception.
- md_resultRDY  in  1  unit result-ready.
- check_busy  out  1  high in any state other than IDLE.
- check_done  out  1  one-cycle completion pulse.
- fault_detected  out  1  verdict; valid only with check_done.
- timeout  out  1  verdict cause; valid only with check_done.
- fault_sticky  out  1  set on any fault; cleared only by reset.
- fault_count  out  8  faults seen; saturates at 255.
- op_count  out  16  completed checks; wraps 0xFFFF to 0.

Function
REQ-003 SHALL implement FSM IDLE -> WAIT_RDY -> COMPUTE -> COMPARE -> IDLE.
REQ-004 In IDLE, exactly one of start_mult/start_div high SHALL capture A, B and op type, then enter WAIT_RDY.
REQ-005 Both starts high in the same cycle SHALL be ignored; state stays IDLE, nothing captured.
REQ-006 Starts while check_busy=1 SHALL be ignored; captured operands SHALL NOT change.
REQ-007 WAIT_RDY SHALL sample md_resultRDY from the first edge after capture; on md_resultRDY=1 it SHALL register md_result, md_remainder, md_exception and enter COMPUTE.
REQ-008 If TIMEOUT_CYCLES edges pass in WAIT_RDY without md_resultRDY, it SHALL go to COMPARE with timeout=1 and fault=1, skipping COMPUTE.
REQ-009 COMPUTE SHALL run a 16-iteration shift-add multiplier, one iteration per cycle, on magnitudes and negate if signs differ, giving a 48-bit signed product. Multiplicand: A for mult, registered md_result for div. Multiplier: B.
REQ-010 Mult check: expected exception = product[47:31] not all equal. Fault if md_exception differs from this. Fault if md_exception=0 and md_result != product[31:0].
REQ-011 Div check, B=0: fault iff md_exception=0; quotient and remainder not checked.
REQ-012 Div check, B!=0: fault if md_exception=1. Fault if product[31:0]+md_remainder != A (mod 2^32). Fault if |md_remainder| >= |B|. Fault if md_remainder nonzero and its sign differs from A.
REQ-013 COMPARE SHALL last one cycle. The next edge SHALL return to IDLE, pulse check_done, present fault_detected/timeout, increment op_count, and, if faulted, set fault_sticky and increment fault_count.
REQ-014 Latency: check_done SHALL rise 18 edges after the edge sampling md_resultRDY=1. On timeout, 2 edges after the last WAIT_RDY edge.
REQ-015 fault_detected and timeout SHALL be 0 whenever check_done=0.
REQ-016 A start in the IDLE cycle in which check_done is high SHALL be accepted.

Reset
REQ-017 reset=1 SHALL force IDLE immediately, asynchronously, from any state including mid-COMPUTE.
REQ-018 Reset SHALL zero all outputs and counters; the in-flight check SHALL be discarded and not counted.

Verification
REQ-019 Mult A=7, B=-3, md_result=0xFFFFFFEB, exc=0 -> check_done 18 edges after RDY, fault_detected=0, op_count=1.
REQ-020 Same, md_result=0xFFFFFFEC -> fault_detected=1, fault_sticky=1, fault_count=1.
REQ-021 Div A=100, B=7: Q=14, R=2 -> fault 0. Q=15, R=2 -> fault 1. Q=13, R=9 -> fault 1 (|R|>=|B|).
REQ-022 Div B=0: exc=1 -> fault 0. exc=0 -> fault 1.
REQ-023 Mult A=0x00010000, B=0x4000, result 0x40000000, exc=0 -> fault 0. A=0x00020000, B=0x4000, exc=0 -> fault 1 (overflow missed).
REQ-024 No md_resultRDY for 64 cycles -> check_done with timeout=1, fault=1. Reset asserted at COMPUTE iteration 8 -> all outputs 0, IDLE, op_count unchanged at 0.
